// File: rtl/dll_code_tracker.sv
// DLL code tracker: loads the SAR result, then performs filtered bang-bang
// tracking on the phase detector decision and reports lock status.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a sar_done rising edge
// LOAD  | one cycle: take sar_code, clear filter, counters and lock
// TRACK | accumulate COMP votes, step the code on a full filter count
// HOLD  | code frozen, filter cleared, lock state kept
module dll_code_tracker #(
    parameter int FILT_TH  = 4,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4
) (
    input  logic       clk4,
    input  logic       rst_n,
    input  logic       sar_done,
    input  logic [9:0] sar_code,
    input  logic       COMP,
    input  logic       track_en,
    output logic [9:0] code,
    output logic [3:0] coarse,
    output logic [5:0] fine,
    output logic       locked,
    output logic       lock_lost,
    output logic       at_limit
);

    typedef enum logic [1:0] {IDLE, LOAD, TRACK, HOLD} state_t;

    localparam logic signed [4:0] TH_POS  = 5'(FILT_TH);
    localparam logic signed [4:0] TH_NEG  = 5'(-FILT_TH);
    localparam logic        [3:0] LOCK_TH = 4'(LOCK_CNT);
    localparam logic        [3:0] LOSS_TH = 4'(LOSS_CNT);

    state_t            state, state_nxt;
    logic              done_q;
    logic signed [4:0] acc, acc_nxt, acc_sum;
    logic        [3:0] rev_cnt, rev_nxt, rev_inc;
    logic        [3:0] same_cnt, same_nxt, same_inc;
    logic              last_dir, last_dir_nxt;
    logic              first_step, first_nxt;
    logic        [9:0] code_nxt;
    logic              locked_nxt, lost_nxt, at_limit_nxt;
    logic              sar_rise, blocked;

    assign sar_rise = sar_done & ~done_q;
    assign acc_sum  = COMP ? acc + 5'sd1 : acc - 5'sd1;
    assign rev_inc  = (rev_cnt  == 4'hF) ? rev_cnt  : rev_cnt  + 4'd1;
    assign same_inc = (same_cnt == 4'hF) ? same_cnt : same_cnt + 4'd1;
    // A step only fires in the direction of the current vote, so the limit
    // test depends on COMP alone.
    assign blocked  = COMP ? (code == 10'h3FF) : (code == 10'h000);

    assign coarse = code[9:6];
    assign fine   = code[5:0];

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk4) begin
        if (!rst_n) begin
            state      <= IDLE;
            done_q     <= 1'b0;
            code       <= '0;
            acc        <= '0;
            rev_cnt    <= '0;
            same_cnt   <= '0;
            last_dir   <= 1'b0;
            first_step <= 1'b0;
            locked     <= 1'b0;
            lock_lost  <= 1'b0;
            at_limit   <= 1'b0;
        end else begin
            state      <= state_nxt;
            done_q     <= sar_done;
            code       <= code_nxt;
            acc        <= acc_nxt;
            rev_cnt    <= rev_nxt;
            same_cnt   <= same_nxt;
            last_dir   <= last_dir_nxt;
            first_step <= first_nxt;
            locked     <= locked_nxt;
            lock_lost  <= lost_nxt;
            at_limit   <= at_limit_nxt;
        end
    end

    // Next-state, filter, step and lock bookkeeping.
    always_comb begin
        state_nxt    = state;
        code_nxt     = code;
        acc_nxt      = acc;
        rev_nxt      = rev_cnt;
        same_nxt     = same_cnt;
        last_dir_nxt = last_dir;
        first_nxt    = first_step;
        locked_nxt   = locked;
        lost_nxt     = 1'b0;
        at_limit_nxt = at_limit;

        case (state)
            IDLE: begin
                if (sar_rise) state_nxt = LOAD;
            end

            LOAD: begin
                code_nxt     = sar_code;
                acc_nxt      = '0;
                rev_nxt      = '0;
                same_nxt     = '0;
                first_nxt    = 1'b1;
                locked_nxt   = 1'b0;
                // a reload that drops an existing lock is still a lock loss
                lost_nxt     = locked;
                at_limit_nxt = 1'b0;
                state_nxt    = track_en ? TRACK : HOLD;
            end

            TRACK: begin
                if (sar_rise) begin
                    state_nxt = LOAD;
                end else if (!track_en) begin
                    // freeze immediately: the vote on this edge is discarded
                    state_nxt = HOLD;
                    acc_nxt   = '0;
                end else if (acc_sum == TH_POS || acc_sum == TH_NEG) begin
                    acc_nxt = '0;
                    if (blocked) begin
                        at_limit_nxt = 1'b1;
                    end else begin
                        code_nxt     = COMP ? code + 10'd1 : code - 10'd1;
                        at_limit_nxt = 1'b0;
                        first_nxt    = 1'b0;
                        last_dir_nxt = COMP;
                        if (first_step || COMP == last_dir) begin
                            same_nxt = same_inc;
                            rev_nxt  = '0;
                            if (locked && same_inc >= LOSS_TH) begin
                                locked_nxt = 1'b0;
                                lost_nxt   = 1'b1;
                            end
                        end else begin
                            rev_nxt  = rev_inc;
                            same_nxt = '0;
                            if (rev_inc >= LOCK_TH) locked_nxt = 1'b1;
                        end
                    end
                end else begin
                    acc_nxt = acc_sum;
                end
            end

            HOLD: begin
                acc_nxt = '0;
                if (sar_rise)      state_nxt = LOAD;
                else if (track_en) state_nxt = TRACK;
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule
